// File: rtl/io_port_ctrl.sv
// io_port_ctrl: CPU IN/OUT port decoder with status/halt port, output latches and FIFO input stream.
// Optional IO_PORT_TRACE_EN adds simulation-only access tracing.
module io_port_ctrl #(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [WORD_SIZE-1:0]           portaddr,
    input  logic [WORD_SIZE-1:0]           portval,
    input  logic                           portget,
    input  logic                           portset,
    output logic [WORD_SIZE-1:0]           portout,
    output logic                           portack,
    output logic                           halted,
    output logic [NUM_PORTS*WORD_SIZE-1:0] port_data,
    output logic [NUM_PORTS-1:0]           port_strobe,
    input  logic [WORD_SIZE-1:0]           in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           err
);

    localparam int AW = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int PW = FW + 1;

    logic [PW-1:0]        wptr, rptr;
    logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] lat [NUM_PORTS];

    logic                 empty, full;
    logic                 is0, is1, in_range;
    logic                 push, pop, wr_go, wr_err, rd_err;
    logic [AW-1:0]        sel;
    logic [WORD_SIZE-1:0] rd_val, status;

    assign is0      = (portaddr == '0);
    assign is1      = (portaddr == WORD_SIZE'(1));
    assign in_range = (portaddr < WORD_SIZE'(NUM_PORTS));
    assign sel      = portaddr[AW-1:0];

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[FW-1:0] == rptr[FW-1:0]) &&
                   (wptr[PW-1] != rptr[PW-1]);

    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = portget && is1 && !empty;
    assign wr_go    = portset && !halted;
    assign wr_err   = wr_go && !in_range;

    assign status = WORD_SIZE'({err, full, !empty, halted});

    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        unique case (1'b1)
            is0: rd_val = status;
            is1: begin
                if (empty) rd_err = 1'b1;
                else       rd_val = mem[rptr[FW-1:0]];
            end
            (in_range && !is0 && !is1): rd_val = lat[sel];
            default: rd_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            portout     <= '0;
            portack     <= 1'b0;
            halted      <= 1'b0;
            port_strobe <= '0;
            err         <= 1'b0;
            wptr        <= '0;
            rptr        <= '0;
            for (int k = 0; k < NUM_PORTS; k++) lat[k] <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
        end else begin
            portack     <= portget || wr_go;
            port_strobe <= '0;
            if (portget) portout <= rd_val;
            if (push) begin
                mem[wptr[FW-1:0]] <= in_data;
                wptr              <= wptr + PW'(1);
            end
            if (pop) rptr <= rptr + PW'(1);
            if ((portget && rd_err) || wr_err) err <= 1'b1;
            if (wr_go && is0) halted <= 1'b1;
            // Latch 0 is never written so slice 0 stays zero.
            if (wr_go && in_range && !is0) begin
                lat[sel]         <= portval;
                port_strobe[sel] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_pd
        assign port_data[k*WORD_SIZE +: WORD_SIZE] = lat[k];
    end

`ifdef IO_PORT_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (wr_go)
                $display("Output %0d on port %0d", portval, portaddr);
            if (portget)
                $display("Input from port %0d", portaddr);
            if (wr_go && is0) begin
                $display("Machine halting");
                $stop;
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed vector table plus hand sequences for FIFO, error,
// reset-abort and halt behaviour of io_port_ctrl.
module tb_io_port_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] portaddr, portval;
    logic        portget, portset;
    logic [15:0] portout;
    logic        portack, halted;
    logic [63:0] port_data;
    logic [3:0]  port_strobe;
    logic [15:0] in_data;
    logic        in_valid, in_ready, err;

    int checks = 0;
    int errors = 0;

    io_port_ctrl #(
        .WORD_SIZE (16),
        .NUM_PORTS (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .portaddr   (portaddr),
        .portval    (portval),
        .portget    (portget),
        .portset    (portset),
        .portout    (portout),
        .portack    (portack),
        .halted     (halted),
        .port_data  (port_data),
        .port_strobe(port_strobe),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        get;
        logic        set;
        logic [15:0] addr;
        logic [15:0] val;
        logic        chk_out;
        logic [15:0] out;
        logic        ack;
        logic [3:0]  strb;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic g, input logic s,
                       input logic [15:0] a, input logic [15:0] v);
        portget  = g;
        portset  = s;
        portaddr = a;
        portval  = v;
        step();
        portget = 1'b0;
        portset = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        portaddr = '0;
        portval  = '0;
        portget  = 1'b0;
        portset  = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;

        tv[0] = '{1'b1, 1'b0, 16'd0, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b0000};
        tv[1] = '{1'b0, 1'b1, 16'd2, 16'h1234, 1'b0, 16'h0000, 1'b1, 4'b0100};
        tv[2] = '{1'b0, 1'b0, 16'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b0000};
        tv[3] = '{1'b1, 1'b0, 16'd2, 16'h0000, 1'b1, 16'h1234, 1'b1, 4'b0000};
        tv[4] = '{1'b0, 1'b1, 16'd3, 16'h0007, 1'b0, 16'h0000, 1'b1, 4'b1000};
        tv[5] = '{1'b1, 1'b0, 16'd3, 16'h0000, 1'b1, 16'h0007, 1'b1, 4'b0000};
        tv[6] = '{1'b0, 1'b1, 16'd1, 16'hABCD, 1'b0, 16'h0000, 1'b1, 4'b0010};
        tv[7] = '{1'b1, 1'b1, 16'd3, 16'h0009, 1'b1, 16'h0007, 1'b1, 4'b1000};
        tv[8] = '{1'b1, 1'b0, 16'd3, 16'h0000, 1'b1, 16'h0009, 1'b1, 4'b0000};
        tv[9] = '{1'b1, 1'b0, 16'd2, 16'h0000, 1'b1, 16'h1234, 1'b1, 4'b0000};

        step();
        step();
        chk("rst portout", portout, 16'h0);
        chk("rst portack", portack, 1'b0);
        chk("rst halted", halted, 1'b0);
        chk("rst port_data", port_data, 64'h0);
        chk("rst strobe", port_strobe, 4'h0);
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst err", err, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            acc(tv[i].get, tv[i].set, tv[i].addr, tv[i].val);
            if (tv[i].chk_out)
                chk($sformatf("v%0d portout", i), portout, tv[i].out);
            chk($sformatf("v%0d portack", i), portack, tv[i].ack);
            chk($sformatf("v%0d strobe", i), port_strobe, tv[i].strb);
            chk($sformatf("v%0d halted", i), halted, 1'b0);
            chk($sformatf("v%0d err", i), err, 1'b0);
        end
        chk("pd slice0", port_data[15:0], 16'h0000);
        chk("pd slice1", port_data[31:16], 16'hABCD);
        chk("pd slice2", port_data[47:32], 16'h1234);
        chk("pd slice3", port_data[63:48], 16'h0009);

        // Fill the FIFO; the fifth word waits for space.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'(10 + i);
            step();
            chk($sformatf("push%0d in_ready", i), in_ready, (i < 3) ? 1'b1 : 1'b0);
        end
        in_data = 16'd14;
        step();
        chk("full hold in_ready", in_ready, 1'b0);
        acc(1'b1, 1'b0, 16'd0, 16'h0);
        chk("status full", portout, 16'h0006);
        acc(1'b1, 1'b0, 16'd1, 16'h0);
        chk("pop0", portout, 16'd10);
        chk("pop0 in_ready", in_ready, 1'b1);
        acc(1'b1, 1'b0, 16'd1, 16'h0);
        in_valid = 1'b0;
        chk("pop1", portout, 16'd11);
        for (int i = 0; i < 3; i++) begin
            acc(1'b1, 1'b0, 16'd1, 16'h0);
            chk($sformatf("pop%0d", i + 2), portout, 16'(12 + i));
            chk($sformatf("pop%0d ack", i + 2), portack, 1'b1);
        end
        acc(1'b1, 1'b0, 16'd0, 16'h0);
        chk("status drained", portout, 16'h0000);

        // Pop on empty while a push lands in the same edge.
        in_valid = 1'b1;
        in_data  = 16'h0077;
        acc(1'b1, 1'b0, 16'd1, 16'h0);
        in_valid = 1'b0;
        chk("empty pop out", portout, 16'h0000);
        chk("empty pop ack", portack, 1'b1);
        chk("empty pop err", err, 1'b1);
        acc(1'b1, 1'b0, 16'd0, 16'h0);
        chk("status nonempty err", portout, 16'h000A);
        acc(1'b1, 1'b0, 16'd1, 16'h0);
        chk("pop after empty", portout, 16'h0077);
        acc(1'b1, 1'b0, 16'd0, 16'h0);
        chk("status err only", portout, 16'h0008);

        do_reset();
        chk("rerst err", err, 1'b0);
        acc(1'b1, 1'b0, 16'd7, 16'h0);
        chk("bad rd out", portout, 16'h0000);
        chk("bad rd ack", portack, 1'b1);
        chk("bad rd err", err, 1'b1);

        do_reset();
        acc(1'b0, 1'b1, 16'd7, 16'h0005);
        chk("bad wr ack", portack, 1'b1);
        chk("bad wr strobe", port_strobe, 4'h0);
        chk("bad wr err", err, 1'b1);
        chk("bad wr pd", port_data, 64'h0);

        // Reset arriving before the edge that would ack.
        do_reset();
        portget  = 1'b1;
        portaddr = 16'd0;
        #3;
        reset = 1'b1;
        step();
        chk("abort ack", portack, 1'b0);
        portget = 1'b0;
        reset   = 1'b0;

        acc(1'b0, 1'b1, 16'd3, 16'h0007);
        chk("pre-halt strobe", port_strobe, 4'b1000);
        acc(1'b0, 1'b1, 16'd0, 16'hFFFF);
        chk("halt ack", portack, 1'b1);
        chk("halt flag", halted, 1'b1);
        chk("halt strobe", port_strobe, 4'h0);
        acc(1'b0, 1'b1, 16'd3, 16'h0055);
        chk("halted wr ack", portack, 1'b0);
        chk("halted wr strobe", port_strobe, 4'h0);
        chk("halted wr latch", port_data[63:48], 16'h0007);
        acc(1'b1, 1'b0, 16'd0, 16'h0);
        chk("halted status", portout, 16'h0001);
        chk("halted rd ack", portack, 1'b1);
        acc(1'b1, 1'b1, 16'd3, 16'h0009);
        chk("halted rw out", portout, 16'h0007);
        chk("halted rw ack", portack, 1'b1);
        chk("halted rw strobe", port_strobe, 4'h0);
        chk("halted rw latch", port_data[63:48], 16'h0007);
        step();
        chk("halted idle ack", portack, 1'b0);
        chk("halted sticky", halted, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
